// File: rtl/usb3_lfps_sched.sv
// LFPS burst scheduler: serialises Polling/Ping/U1/U2-LB/U3 LFPS requests toward the LTSSM.
// Define USB3_LFPS_PING_TIMER_EN to enable autonomous Ping.LFPS generation while idle.
module usb3_lfps_sched #(
   parameter int unsigned TIMEOUT_CYCLES = 20000,
   parameter int unsigned PING_INTERVAL  = 10000
) (
   input  logic       slow_clk,
   input  logic       reset_n,
   input  logic       req_valid,
   input  logic [2:0] req_type,
   input  logic [3:0] req_count,
   output logic       req_ready,
   input  logic       abort,
   input  logic       ping_timer_en,
   output logic       lfps_send_poll,
   output logic       lfps_send_ping,
   output logic       lfps_send_u1,
   output logic       lfps_send_u2lb,
   output logic       lfps_send_u3,
   input  logic       lfps_send_ack,
   output logic       busy,
   output logic       done,
   output logic [2:0] done_type,
   output logic       err,
   output logic       timeout
);

   typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

   state_e      r_state;
   logic [2:0]  r_type;
   logic [3:0]  r_remaining;
   logic [15:0] r_timer;
   logic        r_gap;
   logic [4:0]  r_send;
   logic        r_busy;
   logic        r_ready;
   logic        r_done;
   logic [2:0]  r_done_type;
   logic        r_err;
   logic        r_timeout;
   logic        w_ping_fire;

   // Bit order matches {u3, u2lb, u1, ping, poll}.
   function automatic logic [4:0] type_onehot(input logic [2:0] t);
      logic [4:0] v;
      v = 5'b00000;
      case (t)
         3'd0:    v = 5'b00001;
         3'd1:    v = 5'b00010;
         3'd2:    v = 5'b00100;
         3'd3:    v = 5'b01000;
         3'd4:    v = 5'b10000;
         default: v = 5'b00000;
      endcase
      return v;
   endfunction

`ifdef USB3_LFPS_PING_TIMER_EN
   logic [15:0] r_ping_cnt;
   logic        w_ping_run;

   // External requests always win; any req_valid while idle restarts the interval.
   assign w_ping_run  = (r_state == StIdle) && r_ready && ping_timer_en && !req_valid;
   assign w_ping_fire = w_ping_run && (r_ping_cnt == 16'(PING_INTERVAL - 1));

   always_ff @(posedge slow_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ping_cnt <= 16'd0;
      end else if (w_ping_run && !w_ping_fire) begin
         r_ping_cnt <= r_ping_cnt + 16'd1;
      end else begin
         r_ping_cnt <= 16'd0;
      end
   end
`else
   logic w_unused_ping_en;
   assign w_unused_ping_en = ping_timer_en;
   assign w_ping_fire      = 1'b0;
`endif

   always_ff @(posedge slow_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_type      <= 3'd0;
         r_remaining <= 4'd0;
         r_timer     <= 16'd0;
         r_gap       <= 1'b0;
         r_send      <= 5'b00000;
         r_busy      <= 1'b0;
         r_ready     <= 1'b0;
         r_done      <= 1'b0;
         r_done_type <= 3'd0;
         r_err       <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_timeout <= 1'b0;
         unique case (r_state)
            StIdle: begin
               r_ready <= 1'b1;
               if (r_ready && req_valid) begin
                  if (req_type > 3'd4) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state     <= StSend;
                     r_type      <= req_type;
                     r_remaining <= (req_count == 4'd0) ? 4'd1 : req_count;
                     r_send      <= type_onehot(req_type);
                     r_timer     <= 16'd0;
                     r_busy      <= 1'b1;
                     r_ready     <= 1'b0;
                  end
               end else if (w_ping_fire) begin
                  r_state     <= StSend;
                  r_type      <= 3'd1;
                  r_remaining <= 4'd1;
                  r_send      <= type_onehot(3'd1);
                  r_timer     <= 16'd0;
                  r_busy      <= 1'b1;
                  r_ready     <= 1'b0;
               end
            end
            StSend: begin
               if (abort) begin
                  r_state <= StIdle;
                  r_send  <= 5'b00000;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else if (lfps_send_ack) begin
                  r_remaining <= r_remaining - 4'd1;
                  r_send      <= 5'b00000;
                  if (r_remaining == 4'd1) begin
                     r_state     <= StIdle;
                     r_done      <= 1'b1;
                     r_done_type <= r_type;
                     r_busy      <= 1'b0;
                     r_ready     <= 1'b1;
                  end else begin
                     r_state <= StGap;
                     r_gap   <= 1'b0;
                  end
               end else if (r_timer == 16'(TIMEOUT_CYCLES - 1)) begin
                  r_state   <= StIdle;
                  r_timeout <= 1'b1;
                  r_send    <= 5'b00000;
                  r_busy    <= 1'b0;
                  r_ready   <= 1'b1;
               end else begin
                  r_timer <= r_timer + 16'd1;
               end
            end
            StGap: begin
               if (abort) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
                  r_ready <= 1'b1;
               end else if (r_gap) begin
                  r_state <= StSend;
                  r_send  <= type_onehot(r_type);
                  r_timer <= 16'd0;
               end else begin
                  r_gap <= 1'b1;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign {lfps_send_u3, lfps_send_u2lb, lfps_send_u1, lfps_send_ping, lfps_send_poll} = r_send;
   assign req_ready = r_ready;
   assign busy      = r_busy;
   assign done      = r_done;
   assign done_type = r_done_type;
   assign err       = r_err;
   assign timeout   = r_timeout;

endmodule

// File: tb/tb_usb3_lfps_sched.sv
// Scoreboard bench for usb3_lfps_sched: outcome model pushes expected pulses, a monitor pops them.
// Exercises the ping path differently when USB3_LFPS_PING_TIMER_EN is defined.
module tb_usb3_lfps_sched;

   localparam int TO = 100;
   localparam int PI = 50;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic [2:0] req_type = 3'd0;
   logic [3:0] req_count = 4'd0;
   logic       req_ready;
   logic       abort = 1'b0;
   logic       ping_timer_en = 1'b0;
   logic       lfps_send_poll, lfps_send_ping, lfps_send_u1, lfps_send_u2lb, lfps_send_u3;
   logic       lfps_send_ack = 1'b0;
   logic       busy, done, err, timeout;
   logic [2:0] done_type;
   logic [4:0] sends;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      int         kind;  // 0 done, 1 err, 2 timeout
      logic [2:0] dt;
   } ev_t;
   ev_t exp_q[$];

   usb3_lfps_sched #(.TIMEOUT_CYCLES(TO), .PING_INTERVAL(PI)) dut (
      .slow_clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_type(req_type),
      .req_count(req_count), .req_ready(req_ready), .abort(abort),
      .ping_timer_en(ping_timer_en), .lfps_send_poll(lfps_send_poll),
      .lfps_send_ping(lfps_send_ping), .lfps_send_u1(lfps_send_u1),
      .lfps_send_u2lb(lfps_send_u2lb), .lfps_send_u3(lfps_send_u3),
      .lfps_send_ack(lfps_send_ack), .busy(busy), .done(done), .done_type(done_type),
      .err(err), .timeout(timeout)
   );

   assign sends = {lfps_send_u3, lfps_send_u2lb, lfps_send_u1, lfps_send_ping, lfps_send_poll};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [4:0] exp_onehot(input logic [2:0] t);
      return (t <= 3'd4) ? (5'd1 << t) : 5'd0;
   endfunction

   function automatic void push(input int kind, input logic [2:0] dt);
      ev_t e;
      e.kind = kind;
      e.dt   = dt;
      exp_q.push_back(e);
   endfunction

   // Monitor: every done/err/timeout pulse must match the head of the expectation queue.
   always @(negedge clk) begin
      ev_t e;
      if (reset_n && (done || err || timeout)) begin
         chk("pulse_exclusive", 32'(done) + 32'(err) + 32'(timeout), 32'd1);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", {29'd0, done, err, timeout}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("pulse_kind", done ? 32'd0 : (err ? 32'd1 : 32'd2), e.kind);
            if (e.kind == 0) chk("done_type", {29'd0, done_type}, {29'd0, e.dt});
         end
      end
   end

   // One request. Burst k acks dly[k] cycles after SEND entry; to_burst never acks;
   // abort is raised at cycle ab_off of burst ab_burst; stray acks land in gap cycles.
   task automatic do_req(input logic [2:0] t, input logic [3:0] c, input int fixed_dly,
                         input int to_burst, input int ab_burst, input int ab_off,
                         input bit stray);
      int         n;
      int         endc;
      int         dly[16];
      bit         stop;
      logic [4:0] oh;
      n  = (c == 4'd0) ? 1 : int'(c);
      oh = exp_onehot(t);
      for (int k = 0; k < 16; k++)
         dly[k] = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 12));
      @(negedge clk);
      chk("no_pending_events", exp_q.size(), 0);
      chk("ready_idle", {31'd0, req_ready}, 32'd1);
      if (t > 3'd4) begin
         push(1, 3'd0);
      end else begin
         stop = 1'b0;
         for (int k = 0; k < n && !stop; k++) begin
            endc = (k == to_burst) ? TO - 1 : dly[k];
            if (k == ab_burst && ab_off <= endc) stop = 1'b1;
            else if (k == to_burst) begin push(2, 3'd0); stop = 1'b1; end
         end
         if (!stop) push(0, t);
      end
      req_valid = 1'b1;
      req_type  = t;
      req_count = c;
      @(negedge clk);
      req_valid = 1'b0;
      if (t > 3'd4) begin
         repeat (3) begin
            chk("invalid_no_send", {27'd0, sends}, 32'd0);
            chk("invalid_idle", {30'd0, busy, req_ready}, 32'd1);
            @(negedge clk);
         end
         return;
      end
      for (int k = 0; k < n; k++) begin
         endc = (k == to_burst) ? TO - 1 : dly[k];
         for (int cyc = 0; cyc <= endc; cyc++) begin
            chk("send_on", {27'd0, sends}, {27'd0, oh});
            chk("send_busy", {30'd0, busy, req_ready}, 32'd2);
            if (k == ab_burst && cyc == ab_off) begin
               abort = 1'b1;
               if (k != to_burst && cyc == dly[k]) lfps_send_ack = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               lfps_send_ack = 1'b0;
               chk("abort_send_off", {27'd0, sends}, 32'd0);
               chk("abort_idle", {30'd0, busy, req_ready}, 32'd1);
               return;
            end
            if (cyc == endc && k != to_burst) lfps_send_ack = 1'b1;
            @(negedge clk);
            lfps_send_ack = 1'b0;
         end
         if (k == to_burst || k == n - 1) begin
            chk("end_send_off", {27'd0, sends}, 32'd0);
            chk("end_idle", {30'd0, busy, req_ready}, 32'd1);
            return;
         end
         chk("gap0_off", {27'd0, sends}, 32'd0);
         chk("gap_busy", {31'd0, busy}, 32'd1);
         if (stray) lfps_send_ack = 1'b1;
         @(negedge clk);
         lfps_send_ack = 1'b0;
         chk("gap1_off", {27'd0, sends}, 32'd0);
         @(negedge clk);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int tb;
      int ab;
      int w;
      int act;
      logic [2:0] t;
      logic [3:0] c;

      #1;
      chk("rst_sends", {27'd0, sends}, 32'd0);
      chk("rst_flags", {27'd0, req_ready, busy, done, err, timeout}, 32'd0);
      chk("rst_done_type", {29'd0, done_type}, 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

      do_req(3'd0, 4'd4, 10, -1, -1, 0, 1'b0);     // four poll bursts, one done
      do_req(3'd4, 4'd1, 0, 0, -1, 0, 1'b0);       // no ack: timeout after TO cycles
      do_req(3'd2, 4'd3, 10, -1, 1, 4, 1'b0);      // abort during second burst
      do_req(3'd6, 4'd2, 5, -1, -1, 0, 1'b0);      // invalid type
      do_req(3'd3, 4'd0, 5, -1, -1, 0, 1'b0);      // count 0 -> one burst
      do_req(3'd3, 4'd1, TO - 1, -1, -1, 0, 1'b0); // ack coincides with timeout
      do_req(3'd4, 4'd1, 0, 0, 0, TO - 1, 1'b0);   // abort coincides with timeout
      do_req(3'd1, 4'd2, 3, -1, 0, 3, 1'b0);       // abort coincides with ack
      do_req(3'd0, 4'd3, 2, -1, -1, 0, 1'b1);      // stray acks in gaps ignored
      do_req(3'd2, 4'd15, 0, -1, -1, 0, 1'b0);     // maximum count

      for (int i = 0; i < 25; i++) begin
         t  = 3'($urandom_range(0, 7));
         c  = 4'($urandom_range(0, 5));
         n  = (c == 4'd0) ? 1 : int'(c);
         tb = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         do_req(t, c, -1, tb, ab, int'($urandom_range(0, 14)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            lfps_send_ack = 1'b1;                  // stray ack while idle
            @(negedge clk);
            lfps_send_ack = 1'b0;
            chk("idle_ack_ignored", {26'd0, sends, busy}, 32'd0);
         end
      end

      // Reset in the middle of a Ping burst discards it silently.
      @(negedge clk);
      chk("no_pending_before_rst", exp_q.size(), 0);
      req_valid = 1'b1;
      req_type  = 3'd1;
      req_count = 4'd2;
      @(negedge clk);
      req_valid = 1'b0;
      chk("ping_send_on", {27'd0, sends}, 32'd2);
      repeat (3) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("midrst_sends", {27'd0, sends}, 32'd0);
      chk("midrst_flags", {27'd0, req_ready, busy, done, err, timeout}, 32'd0);
      chk("midrst_done_type", {29'd0, done_type}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      lfps_send_ack = 1'b1;
      @(negedge clk);
      lfps_send_ack = 1'b0;
      chk("postrst_ready", {31'd0, req_ready}, 32'd1);
      repeat (3) begin
         chk("postrst_quiet", {26'd0, sends, busy}, 32'd0);
         @(negedge clk);
      end

`ifdef USB3_LFPS_PING_TIMER_EN
      push(0, 3'd1);
      ping_timer_en = 1'b1;
      w = 0;
      while (sends[1] !== 1'b1 && w < 200) begin
         @(negedge clk);
         w++;
      end
      chk("ping_latency_ok", {31'd0, (w >= PI - 1 && w <= PI + 1)}, 32'd1);
      chk("ping_onehot", {27'd0, sends}, 32'd2);
      lfps_send_ack = 1'b1;
      @(negedge clk);
      lfps_send_ack = 1'b0;
      ping_timer_en = 1'b0;
      chk("ping_done_off", {27'd0, sends}, 32'd0);
      @(negedge clk);
      act = 0;
`else
      ping_timer_en = 1'b1;
      act = 0;
      w = 0;
      repeat (500) begin
         @(negedge clk);
         if (sends != 5'd0 || busy) act++;
      end
      ping_timer_en = 1'b0;
      chk("no_autonomous_ping", act, 0);
`endif
      @(negedge clk);
      chk("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
